hotp_truncate: RTL and testbench

Parametrised HOTP/TOTP dynamic-truncation engine. It sits between the HMAC core and the display driver. It accepts a finished HMAC digest of configurable width, performs RFC 4226 dynamic truncation, and converts the 31-bit result to packed BCD with a sequential double-dabble engine. It emits the low `DIGITS` decimal digits as the one-time code. It supersedes the fixed SHA-1/6-digit truncation block and adds SHA-256 digests, a selectable digit count, a busy flag and defined re-trigger behaviour.

---
 rtl/hotp_pkg.sv | 19 +
 rtl/bcd_adjust.sv | 18 +
 rtl/hotp_truncate.sv | 169 ++++++++++++++++
 tb/tb_hotp_truncate.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hotp_pkg.sv
// hotp_pkg: shared types and constants for the HOTP/TOTP dynamic-truncation engine.
//   state_e      - control FSM states
//   TRUNC_MASK   - clears the sign bit of the extracted 32-bit word
//   BCD_NIBBLES  - width of the BCD accumulator in decimal digits
//   CONV_ITERS   - one double-dabble iteration per bit of the truncated word
package hotp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExtract,
        StConvert,
        StDone
    } state_e;

    localparam logic [30:0]  TRUNC_MASK  = 31'h7FFF_FFFF;
    localparam int unsigned  BCD_NIBBLES = 10;
    localparam int unsigned  CONV_ITERS  = 31;

endpackage

// File: rtl/bcd_adjust.sv
// bcd_adjust: double-dabble correction for one BCD nibble.
// Adds 3 when the nibble is 5 or more so the following left shift carries into
// the next decimal digit.
//   nib_i - current nibble of the BCD accumulator
//   nib_o - corrected nibble, ready to be shifted
module bcd_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/hotp_truncate.sv
// hotp_truncate: HOTP/TOTP dynamic truncation (RFC 4226) followed by a sequential
// binary-to-BCD conversion, producing the low DIGITS decimal digits as the code.
//
// Parameters:
//   DIGEST_W - digest width in bits, multiple of 8, at least 160 (160 SHA-1, 256 SHA-256)
//   DIGITS   - decimal digits delivered on code, 1..10
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   init     - start request; accepted only in IDLE or DONE
//   digest   - HMAC result, byte 0 in the top byte; sampled on the accepting edge
//   code     - packed BCD code, most-significant digit in the top nibble
//   ready    - code is valid (DONE state)
//   busy     - computation in progress (EXTRACT or CONVERT)
//   bin_code - masked truncated word, present only when HOTP_TRUNC_BIN_EN is defined
//
// Latency from the accepting edge to ready is a fixed 33 cycles: one EXTRACT edge
// and 31 CONVERT edges.
module hotp_truncate
    import hotp_pkg::*;
#(
    parameter int unsigned DIGEST_W = 160,
    parameter int unsigned DIGITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic [DIGEST_W-1:0]   digest,
    output logic [4*DIGITS-1:0]   code,
    output logic                  ready,
    output logic                  busy
`ifdef HOTP_TRUNC_BIN_EN
    ,
    output logic [30:0]           bin_code
`endif
);

    localparam int unsigned AccW = 4 * BCD_NIBBLES;
    // Offsets 0..15 reach at most byte 18, so only bytes 0..18 are ever needed.
    localparam int unsigned WinW = 152;

    if ((DIGEST_W % 8) != 0 || DIGEST_W < 160) begin : g_bad_digest_w
        $fatal(1, "hotp_truncate: DIGEST_W must be a multiple of 8 and >= 160");
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $fatal(1, "hotp_truncate: DIGITS must be in 1..10");
    end

    state_e              state_q, state_d;
    logic [WinW-1:0]     window_q, window_d;
    logic [3:0]          offset_q, offset_d;
    logic [30:0]         word_q, word_d;
    logic [AccW-1:0]     acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [4*DIGITS-1:0] code_q, code_d;
`ifdef HOTP_TRUNC_BIN_EN
    logic [30:0]         bin_q, bin_d;
`endif

    logic [31:0]         word_raw;
    logic [30:0]         word_trunc;
    logic [AccW-1:0]     acc_adj;
    logic [AccW-1:0]     acc_shift;

    // Byte-granular window select: offset i picks bytes i..i+3, big-endian.
    always_comb begin
        word_raw = '0;
        for (int i = 0; i < 16; i++) begin
            if (offset_q == 4'(i)) begin
                word_raw = window_q[WinW-1-8*i -: 32];
            end
        end
    end

    // Bit 31 is dropped by the width; the mask keeps the sign-clear intent explicit.
    assign word_trunc = word_raw[30:0] & TRUNC_MASK;

    for (genvar g = 0; g < BCD_NIBBLES; g++) begin : g_adj
        bcd_adjust u_bcd_adjust (
            .nib_i (acc_q[4*g +: 4]),
            .nib_o (acc_adj[4*g +: 4])
        );
    end

    // One double-dabble step: adjusted accumulator takes the next word MSB.
    assign acc_shift = {acc_adj[AccW-2:0], word_q[30]};

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        offset_d = offset_q;
        word_d   = word_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
`ifdef HOTP_TRUNC_BIN_EN
        bin_d    = bin_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (init) begin
                    window_d = digest[DIGEST_W-1 -: WinW];
                    offset_d = digest[3:0];
                    state_d  = StExtract;
                end
            end
            StExtract: begin
                word_d  = word_trunc;
                acc_d   = '0;
                cnt_d   = '0;
`ifdef HOTP_TRUNC_BIN_EN
                bin_d   = word_trunc;
`endif
                state_d = StConvert;
            end
            StConvert: begin
                acc_d  = acc_shift;
                word_d = {word_q[29:0], 1'b0};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'(CONV_ITERS - 1)) begin
                    code_d  = acc_shift[4*DIGITS-1:0];
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            window_q <= '0;
            offset_q <= '0;
            word_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
`ifdef HOTP_TRUNC_BIN_EN
            bin_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            offset_q <= offset_d;
            word_q   <= word_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
`ifdef HOTP_TRUNC_BIN_EN
            bin_q    <= bin_d;
`endif
        end
    end

    assign code  = code_q;
    assign ready = (state_q == StDone);
    assign busy  = (state_q == StExtract) || (state_q == StConvert);
`ifdef HOTP_TRUNC_BIN_EN
    assign bin_code = bin_q;
`endif

    // Bits that can never influence the result.
    logic unused_bits;
    assign unused_bits = ^{digest[DIGEST_W-WinW-1:4], word_raw[31], acc_adj[AccW-1]};

endmodule

// File: tb/tb_hotp_truncate.sv
// Self-checking bench for hotp_truncate: four instances (SHA-1 with 6/8/10 digits,
// SHA-256 with 6 digits) run in lockstep over a table of directed vectors, followed
// by hand-written sequences for init during CONVERT, re-trigger in DONE and reset
// mid-conversion.
module tb_hotp_truncate;

    logic         clk = 1'b0;
    logic         rst;
    logic         init;
    logic [159:0] dig160;
    logic [255:0] dig256;

    logic [23:0]  code6;
    logic [31:0]  code8;
    logic [39:0]  code10;
    logic [23:0]  code256;
    logic         rdy6, bsy6, rdy8, bsy8, rdy10, bsy10, rdy256, bsy256;
`ifdef HOTP_TRUNC_BIN_EN
    logic [30:0]  bin6, bin8, bin10, bin256;
`endif

    always #5 clk = ~clk;

    hotp_truncate #(.DIGEST_W(160), .DIGITS(6)) u_dut6 (
        .clk(clk), .rst(rst), .init(init), .digest(dig160),
        .code(code6), .ready(rdy6), .busy(bsy6)
`ifdef HOTP_TRUNC_BIN_EN
        , .bin_code(bin6)
`endif
    );

    hotp_truncate #(.DIGEST_W(160), .DIGITS(8)) u_dut8 (
        .clk(clk), .rst(rst), .init(init), .digest(dig160),
        .code(code8), .ready(rdy8), .busy(bsy8)
`ifdef HOTP_TRUNC_BIN_EN
        , .bin_code(bin8)
`endif
    );

    hotp_truncate #(.DIGEST_W(160), .DIGITS(10)) u_dut10 (
        .clk(clk), .rst(rst), .init(init), .digest(dig160),
        .code(code10), .ready(rdy10), .busy(bsy10)
`ifdef HOTP_TRUNC_BIN_EN
        , .bin_code(bin10)
`endif
    );

    hotp_truncate #(.DIGEST_W(256), .DIGITS(6)) u_dut256 (
        .clk(clk), .rst(rst), .init(init), .digest(dig256),
        .code(code256), .ready(rdy256), .busy(bsy256)
`ifdef HOTP_TRUNC_BIN_EN
        , .bin_code(bin256)
`endif
    );

    typedef struct {
        logic [159:0] d160;
        logic [255:0] d256;
        logic [23:0]  e6;
        logic [31:0]  e8;
        logic [39:0]  e10;
        logic [23:0]  e256;
        logic [30:0]  ebin;
    } vec_t;

    // SHA-256 boundary: offset 15, bytes 15..18 zero, everything else ones.
    localparam logic [255:0] B0 = {{15{8'hFF}}, 32'h0, {12{8'hFF}}, 8'h0F};
    // SHA-256 offset 2 carrying the RFC word 0x50EF7F19.
    localparam logic [255:0] B1 = {16'h0, 32'h50EF7F19, 200'h0, 8'h02};

    vec_t vecs [8];
    int   total = 0;
    int   bad   = 0;
    int   lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Accept one digest pair and wait (bounded) for ready; lat counts edges from the
    // accepting edge (edge 1) to the edge after which ready is high.
    task automatic run_vec(input logic [159:0] d1, input logic [255:0] d2, input bit pulse,
                           output int lat_o);
        @(negedge clk);
        dig160 = d1;
        dig256 = d2;
        init   = 1'b1;
        @(posedge clk);
        #1;
        init  = 1'b0;
        lat_o = 1;
        chk("accept_busy", {62'd0, bsy6, rdy6}, 64'h2);
        while (!rdy6 && lat_o < 100) begin
            if (pulse && (lat_o == 1 || lat_o == 15 || lat_o == 32)) begin
                init   = 1'b1;
                dig160 = ~dig160;
                dig256 = ~dig256;
            end
            @(posedge clk);
            #1;
            init = 1'b0;
            lat_o++;
        end
    endtask

    task automatic wait_ready(output int lat_o);
        lat_o = 1;
        while (!rdy6 && lat_o < 100) begin
            @(posedge clk);
            #1;
            lat_o++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{160'h1f8698690e02ca16618550ef7f19da8e945b555a, B0,
                    24'h872921, 32'h57872921, 40'h1357872921, 24'h000000, 31'h50EF7F19};
        vecs[1] = '{160'h0e6921efd6b0ee7cefd925b080a3dc19acc69fd1, B1,
                    24'h831766, 32'h63831766, 40'h1763831766, 24'h872921, 31'h6921EFD6};
        vecs[2] = '{{160{1'b1}}, B0,
                    24'h483647, 32'h47483647, 40'h2147483647, 24'h000000, 31'h7FFFFFFF};
        vecs[3] = '{160'h0, B1,
                    24'h000000, 32'h00000000, 40'h0000000000, 24'h872921, 31'h00000000};
        vecs[4] = '{{32'h80000001, 128'h0}, B0,
                    24'h000001, 32'h00000001, 40'h0000000001, 24'h000000, 31'h00000001};
        vecs[5] = '{{40'h0, 32'h3B9AC9FF, 80'h0, 8'h05}, B1,
                    24'h999999, 32'h99999999, 40'h0999999999, 24'h872921, 31'h3B9AC9FF};
        vecs[6] = '{{96'h0, 32'h3B9ACA00, 24'h0, 8'h0C}, B0,
                    24'h000000, 32'h00000000, 40'h1000000000, 24'h000000, 31'h3B9ACA00};
        vecs[7] = '{{120'h0, 32'h12345678, 8'h1F}, B1,
                    24'h419896, 32'h05419896, 40'h0305419896, 24'h872921, 31'h12345678};

        rst    = 1'b0;
        init   = 1'b0;
        dig160 = '0;
        dig256 = '0;
        #1;
        chk("reset_code6", code6, 0);
        chk("reset_code10", code10, 0);
        chk("reset_ready", {63'd0, rdy6}, 0);
        chk("reset_busy", {63'd0, bsy6}, 0);
`ifdef HOTP_TRUNC_BIN_EN
        chk("reset_bin", bin6, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].d160, vecs[i].d256, 1'b0, lat);
            chk($sformatf("v%0d_latency", i), lat, 33);
            chk($sformatf("v%0d_code6", i), code6, vecs[i].e6);
            chk($sformatf("v%0d_code8", i), code8, vecs[i].e8);
            chk($sformatf("v%0d_code10", i), code10, vecs[i].e10);
            chk($sformatf("v%0d_code256", i), code256, vecs[i].e256);
            chk($sformatf("v%0d_flags", i),
                {60'd0, rdy256, rdy10, rdy8, bsy6}, 64'hE);
`ifdef HOTP_TRUNC_BIN_EN
            chk($sformatf("v%0d_bin", i), bin6, vecs[i].ebin);
`endif
        end

        // Digest changes while idle in DONE must not disturb the held code.
        @(negedge clk);
        dig160 = vecs[0].d160;
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold_code", code6, vecs[7].e6);
        chk("done_hold_ready", {63'd0, rdy6}, 1);

        // init pulses (with changing digest) in EXTRACT and CONVERT are ignored.
        run_vec(vecs[0].d160, B1, 1'b1, lat);
        chk("pulse_latency", lat, 33);
        chk("pulse_code6", code6, 24'h872921);
        chk("pulse_code256", code256, 24'h872921);

        // Re-trigger in DONE with init held high: restarts on every completion.
        @(negedge clk);
        dig160 = vecs[1].d160;
        dig256 = B0;
        init   = 1'b1;
        @(posedge clk);
        #1;
        chk("retrig_drop", {62'd0, rdy6, bsy6}, 64'h1);
        wait_ready(lat);
        chk("retrig_latency", lat, 33);
        chk("retrig_code6", code6, 24'h831766);
        chk("retrig_code8", code8, 32'h63831766);
        chk("retrig_code256", code256, 24'h000000);
        dig160 = vecs[2].d160;
        @(posedge clk);
        #1;
        init = 1'b0;
        chk("hold_restart", {62'd0, rdy6, bsy6}, 64'h1);
        wait_ready(lat);
        chk("hold_latency", lat, 33);
        chk("hold_code6", code6, 24'h483647);
        chk("hold_code10", code10, 40'h2147483647);

        // Reset in the middle of CONVERT clears every output at once.
        @(negedge clk);
        dig160 = vecs[5].d160;
        init   = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        lat  = 1;
        while (lat < 15) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rst = 1'b0;
        #1;
        chk("midrst_code6", code6, 0);
        chk("midrst_code10", code10, 0);
        chk("midrst_flags", {60'd0, rdy6, bsy6, rdy10, bsy10}, 0);
`ifdef HOTP_TRUNC_BIN_EN
        chk("midrst_bin", bin6, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[1].d160, B1, 1'b0, lat);
        chk("postrst_latency", lat, 33);
        chk("postrst_code6", code6, 24'h831766);
        chk("postrst_code10", code10, 40'h1763831766);
        chk("postrst_code256", code256, 24'h872921);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
